// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit (mult_div_unit).
// Opcode and FSM-state enums, plus small opcode decode helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MUL   = 2'b01,
    ST_DIV   = 2'b10,
    ST_FIXUP = 2'b11
  } state_e;

  // Even opcodes (mult, div) treat operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the MIPS datapath and mult_div_unit.
// master = datapath side, slave = the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  start_i;
  logic [1:0]            op_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  hi_write_i;
  logic                  lo_write_i;
  logic [DATA_WIDTH-1:0] write_data_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  div_zero_o;
  logic [DATA_WIDTH-1:0] hi_o;
  logic [DATA_WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, hi_write_i, lo_write_i, write_data_i,
    input  busy_o, done_o, div_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, hi_write_i, lo_write_i, write_data_i,
    output busy_o, done_o, div_zero_o, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_sign_fixup.sv
// Conditional two's-complement negation of a HI/LO pair, either as two
// independent words (abs of operands, quotient/remainder) or as one 2W product.
module mdu_sign_fixup #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  input  logic                  neg_hi,
  input  logic                  neg_lo,
  input  logic                  joined,   // treat {hi,lo} as one value, sign in neg_lo
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  logic [2*DATA_WIDTH-1:0] wide;
  logic [2*DATA_WIDTH-1:0] wide_fixed;
  logic [DATA_WIDTH-1:0]   hi_fixed;
  logic [DATA_WIDTH-1:0]   lo_fixed;

  assign wide       = {hi_in, lo_in};
  assign wide_fixed = neg_lo ? -wide : wide;
  assign hi_fixed   = neg_hi ? -hi_in : hi_in;
  assign lo_fixed   = neg_lo ? -lo_in : lo_in;

  assign hi_out = joined ? wide_fixed[2*DATA_WIDTH-1:DATA_WIDTH] : hi_fixed;
  assign lo_out = joined ? wide_fixed[DATA_WIDTH-1:0]            : lo_fixed;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (mult/multu/div/divu,
// mthi/mtlo). Optional macro MDU_FAST_MULT_EN: single-cycle combinational multiply.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     operand_q;   // multiplicand or divisor magnitude
  logic [2*W-1:0]   acc;         // {upper/remainder, lower/quotient}
  logic             neg_pq, neg_rem, is_mul;
  logic [W-1:0]     hi_q, lo_q;
  logic             done_q, div_zero_q;

  logic             sgn, div_by_zero, last_iter;
  logic [W-1:0]     a_abs, b_abs, fix_hi, fix_lo;
  logic [W:0]       mul_sum, div_shift, div_diff;
  logic [2*W-1:0]   mul_next, div_next;

  assign sgn         = op_is_signed(bus.op_i);
  assign div_by_zero = op_is_div(bus.op_i) && (bus.b_i == '0);
  assign last_iter   = (cnt == CNT_W'(W - 1));

  mdu_sign_fixup #(.DATA_WIDTH(W)) u_entry_fixup (
    .hi_in  (bus.a_i),
    .lo_in  (bus.b_i),
    .neg_hi (sgn & bus.a_i[W-1]),
    .neg_lo (sgn & bus.b_i[W-1]),
    .joined (1'b0),
    .hi_out (a_abs),
    .lo_out (b_abs)
  );

  mdu_sign_fixup #(.DATA_WIDTH(W)) u_exit_fixup (
    .hi_in  (acc[2*W-1:W]),
    .lo_in  (acc[W-1:0]),
    .neg_hi (neg_rem),
    .neg_lo (neg_pq),
    .joined (is_mul),
    .hi_out (fix_hi),
    .lo_out (fix_lo)
  );

  // Shift-add step: add multiplicand when the multiplier LSB is set, shift right.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, operand_q};
  assign mul_next = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};

  // Restoring step: bit W of the difference is the borrow, i.e. "does not fit".
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, operand_q};
  assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                 : {div_diff[W-1:0],  acc[W-2:0], 1'b1};

`ifdef MDU_FAST_MULT_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, a_abs} * {{W{1'b0}}, b_abs};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_next; no latch.
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (op_is_div(bus.op_i)) begin
            state_next = div_by_zero ? ST_FIXUP : ST_DIV;
          end else begin
`ifdef MDU_FAST_MULT_EN
            state_next = ST_FIXUP;
`else
            state_next = ST_MUL;
`endif
          end
        end
      end
      ST_MUL, ST_DIV: if (last_iter) state_next = ST_FIXUP;
      ST_FIXUP:       state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      operand_q  <= '0;
      acc        <= '0;
      neg_pq     <= 1'b0;
      neg_rem    <= 1'b0;
      is_mul     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            cnt        <= '0;
            div_zero_q <= div_by_zero;
            is_mul     <= ~op_is_div(bus.op_i);
            neg_pq     <= ~div_by_zero & sgn & (bus.a_i[W-1] ^ bus.b_i[W-1]);
            neg_rem    <= ~div_by_zero & sgn & bus.a_i[W-1];
            if (op_is_div(bus.op_i)) begin
              operand_q <= b_abs;
              acc       <= div_by_zero ? {bus.a_i, {W{1'b1}}} : {{W{1'b0}}, a_abs};
            end else begin
              operand_q <= a_abs;
`ifdef MDU_FAST_MULT_EN
              acc       <= fast_prod;
`else
              acc       <= {{W{1'b0}}, b_abs};
`endif
            end
          end else begin
            if (bus.hi_write_i) hi_q <= bus.write_data_i;
            if (bus.lo_write_i) lo_q <= bus.write_data_i;
          end
        end
        ST_MUL: begin
          acc <= mul_next;
          cnt <= cnt + CNT_W'(1);
        end
        ST_DIV: begin
          acc <= div_next;
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIXUP: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stall the issuing instruction combinationally, before the FSM leaves IDLE.
  assign bus.busy_o     = (state != ST_IDLE) || bus.start_i;
  assign bus.done_o     = done_q;
  assign bus.div_zero_o = div_zero_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;

endmodule
